// File: rtl/shield_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : shield_write_arbiter
//  Description : Shares the colorshield pixel write port between a host pixel
//                source (A) and a pattern/animation generator (B). Round-robin
//                arbitration with burst ownership: the owner may push up to
//                BURST_LEN accepted writes before the other side gets a turn.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BURST_LEN   max accepted writes per ownership period (1..64)
//  Ports
//    clk          in   1   clock
//    rst_n        in   1   asynchronous, active-low reset
//    a_req        in   1   A write pending (addr/data stable until a_ack)
//    a_addr       in   6   A pixel address
//    a_data       in   24  A pixel value {R,G,B}
//    a_ack        out  1   A write accepted this cycle (combinational)
//    b_req        in   1   B write pending
//    b_addr       in   6   B pixel address
//    b_data       in   24  B pixel value {R,G,B}
//    b_ack        out  1   B write accepted this cycle (combinational)
//    ready        in   1   colorshield ready; write taken on write_en & ready
//    write_en     out  1   colorshield write enable
//    pixel_addr   out  6   colorshield pixel address
//    pixel_value  out  24  colorshield pixel value
//    owner        out  2   00 none, 01 A, 10 B (registered)
// ============================================================================
module shield_write_arbiter #(
   parameter int BURST_LEN = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [5:0]  a_addr,
   input  logic [23:0] a_data,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [5:0]  b_addr,
   input  logic [23:0] b_data,
   output logic        b_ack,
   input  logic        ready,
   output logic        write_en,
   output logic [5:0]  pixel_addr,
   output logic [23:0] pixel_value,
   output logic [1:0]  owner
);

   localparam int                 c_CNT_W     = $clog2(BURST_LEN + 1);
   localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(BURST_LEN);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   // State encoding doubles as the owner output code.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_OWN_A = 2'b01,
      ST_OWN_B = 2'b10
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   state_t               w_other_state;
   logic [c_CNT_W-1:0]   r_burst_cnt;
   logic [c_CNT_W-1:0]   w_burst_cnt_nxt;
   logic [c_CNT_W-1:0]   w_cnt_inc;
   logic                 r_last;          // 1 = B was granted most recently
   logic                 w_last_nxt;
   logic                 w_own_a;
   logic                 w_own_b;
   logic                 w_own_req;
   logic                 w_oth_req;
   logic                 w_accept;
   logic                 w_burst_done;

   // ------------------------------------------------------------------------
   // Owner-relative views so the OWN_A / OWN_B handling is written once.
   // ------------------------------------------------------------------------
   assign w_own_a       = (r_state == ST_OWN_A);
   assign w_own_b       = (r_state == ST_OWN_B);
   assign w_own_req     = w_own_a ? a_req : b_req;
   assign w_oth_req     = w_own_a ? b_req : a_req;
   assign w_other_state = w_own_a ? ST_OWN_B : ST_OWN_A;
   assign w_accept      = (w_own_a | w_own_b) & w_own_req & ready;
   assign w_cnt_inc     = r_burst_cnt + c_CNT_ONE;
   assign w_burst_done  = (w_cnt_inc == c_BURST_MAX);

   // ------------------------------------------------------------------------
   // Datapath: the owner's request is forwarded straight to the shield.
   // ------------------------------------------------------------------------
   assign a_ack    = w_own_a & a_req & ready;
   assign b_ack    = w_own_b & b_req & ready;
   assign write_en = (w_own_a & a_req) | (w_own_b & b_req);
   assign owner    = r_state;

   always_comb begin
      pixel_addr  = '0;
      pixel_value = '0;
      if (w_own_a) begin
         pixel_addr  = a_addr;
         pixel_value = a_data;
      end else if (w_own_b) begin
         pixel_addr  = b_addr;
         pixel_value = b_data;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_burst_cnt <= '0;
         r_last      <= 1'b1;             // A wins the first tie
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_last      <= w_last_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_burst_cnt_nxt = r_burst_cnt;
      w_last_nxt      = r_last;

      case (r_state)
         ST_IDLE: begin
            // On a tie the side that was not served last goes first.
            if (a_req && (!b_req || r_last)) begin
               w_state_nxt     = ST_OWN_A;
               w_burst_cnt_nxt = '0;
               w_last_nxt      = 1'b0;
            end else if (b_req) begin
               w_state_nxt     = ST_OWN_B;
               w_burst_cnt_nxt = '0;
               w_last_nxt      = 1'b1;
            end
         end

         ST_OWN_A, ST_OWN_B: begin
            if (!w_own_req) begin
               // Owner released: hand over immediately if the other side waits.
               w_burst_cnt_nxt = '0;
               if (w_oth_req) begin
                  w_state_nxt = w_other_state;
                  w_last_nxt  = w_own_a;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_accept) begin
               if (w_burst_done) begin
                  w_burst_cnt_nxt = '0;
                  if (w_oth_req) begin
                     w_state_nxt = w_other_state;
                     w_last_nxt  = w_own_a;
                  end
                  // Otherwise the owner keeps the port for a fresh burst.
               end else begin
                  w_burst_cnt_nxt = w_cnt_inc;
               end
            end
            // ready low with the request held: everything holds.
         end

         default: begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = '0;
         end
      endcase
   end

endmodule
`default_nettype wire
